// File: rtl/sbox_pkg.sv
// sbox_pkg
// Shared definitions for the sequential AES SubBytes/InvSubBytes engine.
//
// GF(2^8) is handled as the composite field GF((2^4)^2) with the extension
// polynomial y^2 + y + LAMBDA. GF(2^4) is in turn the tower GF((2^2)^2) with
// z^2 + z + PHI over GF(2^2) = GF(2)[w]/(w^2 + w + 1). The 4-bit multiplier,
// squarer, constant multiplier and inverter below all use that tower basis,
// and MAP_M / INV_MAP_M are the isomorphism between the AES polynomial
// basis and this composite basis.
//
// Contents:
//   state_t              FSM encoding (IDLE/CALC/DONE)
//   LAMBDA, PHI          field constants of the tower
//   MAP_M, INV_MAP_M     isomorphic map and its inverse
//   AFF_M, INV_AFF_M     affine and inverse affine matrices
//   AFF_C, INV_AFF_C     affine constants 0x63 and 0x05
//   mat8()               8x8 GF(2) matrix-vector product
//   gf22_*, gf24_*       GF(2^2) and GF(2^4) arithmetic helpers
package sbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // y^2 + y + LAMBDA over GF(2^4); LAMBDA = {11,00} in the tower basis.
  localparam logic [3:0] LAMBDA = 4'hC;
  // z^2 + z + PHI over GF(2^2); PHI = w.
  localparam logic [1:0] PHI = 2'b10;

  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  // Matrices are stored as {row7, ..., row0}; row i is the mask of input
  // bits XORed together to form output bit i.
  localparam logic [7:0][7:0] MAP_M = {
    8'hA0, 8'hDE, 8'hAC, 8'hAE, 8'hC6, 8'h9E, 8'h52, 8'h43
  };
  localparam logic [7:0][7:0] INV_MAP_M = {
    8'hE2, 8'h44, 8'h62, 8'h76, 8'h3E, 8'h9E, 8'h30, 8'h75
  };
  // b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7), indices mod 8.
  localparam logic [7:0][7:0] AFF_M = {
    8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1
  };
  // a_i = b_(i+2) ^ b_(i+5) ^ b_(i+7), indices mod 8.
  localparam logic [7:0][7:0] INV_AFF_M = {
    8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4
  };

  function automatic logic [7:0] mat8(input logic [7:0][7:0] m,
                                      input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(m[i] & x);
    end
    return y;
  endfunction

  // GF(2^2) multiply, w^2 = w + 1.
  function automatic logic [1:0] gf22_mul(input logic [1:0] a,
                                          input logic [1:0] b);
    logic [1:0] p;
    p[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    p[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return p;
  endfunction

  function automatic logic [1:0] gf22_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // In GF(2^2) the inverse of a non-zero element is its square; 0 maps to 0.
  function automatic logic [1:0] gf22_inv(input logic [1:0] a);
    return gf22_sq(a);
  endfunction

  // Multiply by PHI = w.
  function automatic logic [1:0] gf22_mul_phi(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  // GF(2^4) multiply in the tower basis: (ah z + al)(bh z + bl), z^2 = z + PHI.
  function automatic logic [3:0] gf24_mul(input logic [3:0] a,
                                          input logic [3:0] b);
    logic [1:0] hh;
    logic [1:0] ph;
    logic [1:0] pl;
    hh = gf22_mul(a[3:2], b[3:2]);
    ph = hh ^ gf22_mul(a[3:2], b[1:0]) ^ gf22_mul(a[1:0], b[3:2]);
    pl = gf22_mul_phi(hh) ^ gf22_mul(a[1:0], b[1:0]);
    return {ph, pl};
  endfunction

  function automatic logic [3:0] gf24_sq(input logic [3:0] a);
    return gf24_mul(a, a);
  endfunction

  function automatic logic [3:0] gf24_mul_lambda(input logic [3:0] a);
    return gf24_mul(a, LAMBDA);
  endfunction

  // (h z + l)^-1 = h d z + (h + l) d with d = (h^2 PHI + h l + l^2)^-1.
  // A zero input gives d = 0 and hence a zero result.
  function automatic logic [3:0] gf24_inv(input logic [3:0] a);
    logic [1:0] h;
    logic [1:0] l;
    logic [1:0] d;
    h = a[3:2];
    l = a[1:0];
    d = gf22_inv(gf22_mul_phi(gf22_sq(h)) ^ gf22_mul(h, l) ^ gf22_sq(l));
    return {gf22_mul(h, d), gf22_mul(h ^ l, d)};
  endfunction

endpackage

// File: rtl/sbox_byte_comb.sv
// sbox_byte_comb
// Purely combinational AES S-box / inverse S-box for one byte, built on the
// composite field GF((2^4)^2).
//
// Ports:
//   inv   0 = forward S-box, 1 = inverse S-box
//   din   input byte
//   dout  substituted byte
//
// Forward: map -> GF(2^8) inverse -> inverse map -> affine (0x63).
// Inverse: inverse affine (0x05) -> map -> GF(2^8) inverse -> inverse map.
module sbox_byte_comb
  import sbox_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pre;
  logic [7:0] iso;
  logic [3:0] hi;
  logic [3:0] lo;
  logic [3:0] hl_prod;
  logic [3:0] norm;
  logic [3:0] norm_inv;
  logic [3:0] out_hi;
  logic [3:0] out_lo;
  logic [7:0] inv_iso;

  // Input side: optional inverse affine, then into the composite basis.
  always_comb begin
    pre = inv ? (mat8(INV_AFF_M, din) ^ INV_AFF_C) : din;
    iso = mat8(MAP_M, pre);
    hi  = iso[7:4];
    lo  = iso[3:0];
  end

  // GF((2^4)^2) inversion of (hi y + lo) with y^2 = y + LAMBDA:
  // result = hi d y + (hi + lo) d, d = (hi^2 LAMBDA + hi lo + lo^2)^-1.
  // Three general multipliers, one squarer pair, one constant multiply.
  always_comb begin
    hl_prod  = gf24_mul(hi, lo);
    norm     = gf24_mul_lambda(gf24_sq(hi)) ^ hl_prod ^ gf24_sq(lo);
    norm_inv = gf24_inv(norm);
    out_hi   = gf24_mul(hi, norm_inv);
    out_lo   = gf24_mul(hi ^ lo, norm_inv);
  end

  // Output side: back to the AES basis, then the forward affine if needed.
  always_comb begin
    inv_iso = mat8(INV_MAP_M, {out_hi, out_lo});
    dout    = inv ? inv_iso : (mat8(AFF_M, inv_iso) ^ AFF_C);
  end

endmodule

// File: rtl/sbox_word_seq.sv
// sbox_word_seq
// Sequential SubBytes/InvSubBytes engine: accepts one NBYTES-byte word,
// substitutes one byte per clock through a single sbox_byte_comb, and
// presents the finished word on a valid/ready output.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   IN_VALID   input word valid
//   IN_READY   engine idle and able to accept a word (registered)
//   INV        mode sampled with the word: 0 forward, 1 inverse
//   DIN        input word, byte i = DIN[8i+7:8i]
//   OUT_VALID  result valid (registered)
//   OUT_READY  consumer accepts the result
//   DOUT       result word, same byte order; held after the handshake
//
// Timing: word accepted at edge k, bytes 0..NBYTES-1 written on edges
// k+1..k+NBYTES, OUT_VALID visible after edge k+NBYTES.
module sbox_word_seq
  import sbox_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  INV,
  input  logic [8*NBYTES-1:0]   DIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [8*NBYTES-1:0]   DOUT
);

  localparam int W  = 8 * NBYTES;
  // Keep the counter at least one bit wide so NBYTES = 1 still elaborates.
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            inv_q;
  logic [W-1:0]    work;

  logic [7:0]      cur_byte;
  logic [7:0]      sub_byte;
  logic [W-1:0]    work_next;

  // Select the byte under substitution and rebuild the word with it replaced.
  always_comb begin
    cur_byte  = work[{cnt, 3'b000} +: 8];
    work_next = work;
    work_next[{cnt, 3'b000} +: 8] = sub_byte;
  end

  sbox_byte_comb u_sbox (
    .inv  (inv_q),
    .din  (cur_byte),
    .dout (sub_byte)
  );

  // Control FSM with counter, work register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= {CW{1'b0}};
      inv_q     <= 1'b0;
      work      <= {W{1'b0}};
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      DOUT      <= {W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            work     <= DIN;
            inv_q    <= INV;
            cnt      <= {CW{1'b0}};
            IN_READY <= 1'b0;
            state    <= ST_CALC;
          end else begin
            IN_READY <= 1'b1;
          end
        end
        ST_CALC: begin
          work <= work_next;
          if (cnt == LAST) begin
            // The completed word (with the last byte just substituted) goes
            // straight to DOUT so it is valid together with OUT_VALID.
            cnt       <= {CW{1'b0}};
            DOUT      <= work_next;
            OUT_VALID <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            OUT_VALID <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= {CW{1'b0}};
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_word_seq.sv
// tb_sbox_word_seq
// Directed self-checking bench for sbox_word_seq (NBYTES = 4): hand-computed
// words, back-pressure, ignored input while busy, mid-CALC reset, and a full
// byte sweep in both modes against the reference AES S-box table.
module tb_sbox_word_seq;

  logic        clk;
  logic        rst;
  logic        IN_VALID;
  logic        IN_READY;
  logic        INV;
  logic [31:0] DIN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] DOUT;

  int n_cmp;
  int n_err;

  logic [7:0] sbox_tbl [0:255];
  logic [7:0] inv_tbl  [0:255];

  sbox_word_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INV       (INV),
    .DIN       (DIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DOUT      (DOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present a word once the engine is ready; returns at the negedge after the accept edge.
  task automatic send_word(input logic [31:0] w, input logic m);
    int t;
    t = 0;
    while (!IN_READY && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", {31'b0, IN_READY}, 32'd1);
    IN_VALID = 1'b1;
    DIN      = w;
    INV      = m;
    @(posedge clk);
    @(negedge clk);
    IN_VALID = 1'b0;
  endtask

  // Count negedges until OUT_VALID is seen, bounded.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!OUT_VALID && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic take_out();
    OUT_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    OUT_READY = 1'b0;
    chk("ov_drop", {31'b0, OUT_VALID}, 32'd0);
    chk("ir_back", {31'b0, IN_READY}, 32'd1);
  endtask

  task automatic run_word(input string tag, input logic [31:0] w, input logic m,
                          input logic [31:0] exp);
    int lat;
    send_word(w, m);
    wait_out(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_dout"}, DOUT, exp);
    take_out();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] fexp;
    logic [31:0] iexp;
    int lat;
    logic saw;

    sbox_tbl = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    for (int i = 0; i < 256; i++) inv_tbl[sbox_tbl[i]] = 8'(i);

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    IN_VALID  = 1'b0;
    INV       = 1'b0;
    DIN       = 32'h0;
    OUT_READY = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_dout", DOUT, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic forward word with latency and DOUT retention after handshake
    run_word("fwd_basic", 32'h00015353, 1'b0, 32'h637CEDED);
    chk("dout_hold_after", DOUT, 32'h637CEDED);

    // Basic inverse word
    run_word("inv_basic", 32'h637CEDED, 1'b1, 32'h00015353);

    // Back-pressure: OUT_READY low for 5 cycles
    send_word(32'hFFFFFFFF, 1'b0);
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_dout", DOUT, 32'h16161616);
      chk("bp_ov", {31'b0, OUT_VALID}, 32'd1);
      chk("bp_ir", {31'b0, IN_READY}, 32'd0);
      @(negedge clk);
    end
    chk("bp_dout_final", DOUT, 32'h16161616);
    take_out();

    // Input activity while busy is ignored
    send_word(32'h11223344, 1'b0);
    chk("busy_ir", {31'b0, IN_READY}, 32'd0);
    IN_VALID = 1'b1;
    DIN      = 32'hAAAAAAAA;
    INV      = 1'b1;
    wait_out(lat);
    IN_VALID = 1'b0;
    chk("busy_lat", 32'(lat), 32'd4);
    chk("busy_dout", DOUT, 32'h8293C31B);
    take_out();

    // Reset two cycles after accept aborts the word
    send_word(32'h01020304, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("abort_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("abort_dout", DOUT, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (OUT_VALID) saw = 1'b1;
    end
    chk("abort_no_out", {31'b0, saw}, 32'd0);
    run_word("after_abort", 32'h53000163, 1'b0, 32'hED637CFB);

    // Byte sweep: forward vs table, round trip, inverse vs inverted table
    for (int j = 0; j < 64; j++) begin
      for (int b = 0; b < 4; b++) begin
        w[8*b +: 8]    = 8'(4*j + b);
        fexp[8*b +: 8] = sbox_tbl[8'(4*j + b)];
        iexp[8*b +: 8] = inv_tbl[8'(4*j + b)];
      end
      run_word("sweep_fwd", w, 1'b0, fexp);
      run_word("sweep_rt", fexp, 1'b1, w);
      run_word("sweep_inv", w, 1'b1, iexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
